// File: rtl/alu_shift_pkg.sv
// Shared definitions for the shift/rotate/funnel unit: funct codes,
// FSM state encoding and default geometry.
package alu_shift_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_STEP  = 4;

   localparam logic [2:0] FUNCT_SHL  = 3'b000;
   localparam logic [2:0] FUNCT_SHR  = 3'b001;
   localparam logic [2:0] FUNCT_ASHR = 3'b010;
   localparam logic [2:0] FUNCT_FSHR = 3'b011;
   localparam logic [2:0] FUNCT_ROL  = 3'b100;
   localparam logic [2:0] FUNCT_ROR  = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_shift_pipe_if.sv
// Request/response bundle of the shift unit.
// slave  : the shift unit (takes requests, presents results)
// master : the dispatch side (issues requests, consumes results)
interface alu_shift_pipe_if
   import alu_shift_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int SHAMT_W = $clog2(WIDTH)
) ();

   logic               valid_i;
   logic               ready_o;
   logic [2:0]         funct;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic [SHAMT_W-1:0] shamt;
   logic               valid_o;
   logic               ready_i;
   logic [WIDTH-1:0]   result;

   modport slave (
      input  valid_i, funct, a, b, shamt, ready_i,
      output ready_o, valid_o, result
   );

   modport master (
      output valid_i, funct, a, b, shamt, ready_i,
      input  ready_o, valid_o, result
   );

endinterface

// File: rtl/alu_shift_core.sv
// Single-cycle combinational shifter: SHL, SHR, ASHR and, when
// ALU_SHIFT_ROTATE_EN is defined, ROL/ROR. Any other code returns a.
module alu_shift_core
   import alu_shift_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic [2:0]         funct,
   input  logic [WIDTH-1:0]   a,
   input  logic [SHAMT_W-1:0] shamt,
   output logic [WIDTH-1:0]   result
);

`ifdef ALU_SHIFT_ROTATE_EN
   // Complementary amount; equals WIDTH for shamt==0 so the wrap term is zero.
   logic [SHAMT_W:0] inv_amt;
   assign inv_amt = (SHAMT_W+1)'(WIDTH) - {1'b0, shamt};
`endif

   // Operation select; unknown/illegal codes pass a through.
   always_comb begin
      result = a;
      case (funct)
         FUNCT_SHL:  result = a << shamt;
         FUNCT_SHR:  result = a >> shamt;
         FUNCT_ASHR: result = $signed(a) >>> shamt;
`ifdef ALU_SHIFT_ROTATE_EN
         FUNCT_ROL:  result = (a << shamt) | (a >> inv_amt);
         FUNCT_ROR:  result = (a >> shamt) | (a << inv_amt);
`endif
         default:    result = a;
      endcase
   end

endmodule

// File: rtl/alu_shift_pipe.sv
// Shift/rotate/funnel execution unit.
// Optional rotate support: define ALU_SHIFT_ROTATE_EN.
//
// Handshake: a request transfers on a rising edge where valid_i && ready_o;
// a result transfers on a rising edge where valid_o && ready_i. A requester
// holds its request until ready_o; the unit holds valid_o and result stable
// until ready_i. ready_o depends combinationally on ready_i only in DONE,
// which lets a new request enter in the same cycle a result leaves.
//
// Simple ops complete in one cycle. FSHR loads {a,b} into a double-width
// work register and shifts it right STEP bits per BUSY cycle.
module alu_shift_pipe
   import alu_shift_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int STEP    = DEFAULT_STEP,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic              clk,
   input  logic              reset,
   alu_shift_pipe_if.slave   bus,
   output state_t            state_dbg
);

   localparam logic [SHAMT_W:0] STEP_L = (SHAMT_W+1)'(STEP);

   state_t               state_q, state_d;
   logic [2*WIDTH-1:0]   work_q, work_d;
   logic [SHAMT_W-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]     result_q, result_d;

   logic                 ready_int;
   logic                 accept;
   logic [WIDTH-1:0]     core_result;
   logic [SHAMT_W:0]     step_amt;
   logic [2*WIDTH-1:0]   work_shift;
   logic [SHAMT_W-1:0]   rem_next;

   alu_shift_core #(
      .WIDTH   (WIDTH),
      .SHAMT_W (SHAMT_W)
   ) u_core (
      .funct  (bus.funct),
      .a      (bus.a),
      .shamt  (bus.shamt),
      .result (core_result)
   );

   assign ready_int   = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.ready_i);
   assign accept      = bus.valid_i && ready_int;
   assign bus.ready_o = ready_int;
   assign bus.valid_o = (state_q == ST_DONE);
   assign bus.result  = result_q;
   assign state_dbg   = state_q;

   // Funnel step: min(STEP, remaining) bits this cycle.
   always_comb begin
      step_amt   = ({1'b0, rem_q} < STEP_L) ? {1'b0, rem_q} : STEP_L;
      work_shift = work_q >> step_amt;
      rem_next   = rem_q - step_amt[SHAMT_W-1:0];
   end

   // Next-state and datapath update for the IDLE/BUSY/DONE controller.
   always_comb begin
      state_d  = state_q;
      work_d   = work_q;
      rem_d    = rem_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if ((state_q == ST_DONE) && bus.ready_i) begin
               state_d = ST_IDLE;
            end
            if (accept) begin
               if (bus.funct == FUNCT_FSHR) begin
                  work_d = {bus.a, bus.b};
                  rem_d  = bus.shamt;
                  if (bus.shamt == '0) begin
                     result_d = bus.b;
                     state_d  = ST_DONE;
                  end else begin
                     state_d  = ST_BUSY;
                  end
               end else begin
                  result_d = core_result;
                  state_d  = ST_DONE;
               end
            end
         end
         ST_BUSY: begin
            work_d = work_shift;
            rem_d  = rem_next;
            if (rem_next == '0) begin
               result_d = work_shift[WIDTH-1:0];
               state_d  = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset discards any in-flight operation.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         work_q   <= '0;
         rem_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         work_q   <= work_d;
         rem_q    <= rem_d;
         result_q <= result_d;
      end
   end

endmodule

// File: tb/tb_alu_shift_pipe.sv
// Self-checking bench for alu_shift_pipe (WIDTH=32, STEP=4).
// Rotate expectations follow ALU_SHIFT_ROTATE_EN.
module tb_alu_shift_pipe;
   import alu_shift_pkg::*;

   localparam int W    = 32;
   localparam int STEP = 4;
   localparam int SW   = 5;

   // ---------------- clock / reset ----------------
   logic   clk   = 1'b0;
   logic   reset = 1'b1;
   state_t state_dbg;
   int     cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   alu_shift_pipe_if #(.WIDTH(W)) bus ();

   alu_shift_pipe #(
      .WIDTH (W),
      .STEP  (STEP)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // ---------------- scoreboard ----------------
   int           n_cmp = 0;
   int           n_err = 0;
   logic [W-1:0] exp_q[$];
   int           lat_q[$];
   int           acc_q[$];
   bit           mon_ev;

   task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: result straight from the operation definitions.
   function automatic logic [W-1:0] ref_op(input logic [2:0] f, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input int s);
      logic [2*W-1:0] cat;
      logic [W-1:0]   r;
      r = a;
      case (f)
         3'd0: r = a << s;
         3'd1: r = a >> s;
         3'd2: r = a[W-1] ? ~((~a) >> s) : (a >> s);
         3'd3: begin
            cat = {a, b};
            cat = cat >> s;
            r   = cat[W-1:0];
         end
`ifdef ALU_SHIFT_ROTATE_EN
         3'd4: repeat (s) r = {r[W-2:0], r[W-1]};
         3'd5: repeat (s) r = {r[0], r[W-1:1]};
`endif
         default: r = a;
      endcase
      return r;
   endfunction

   // Clock edges from the accepting edge until the result is presented.
   function automatic int ref_lat(input logic [2:0] f, input int s);
      if (f == 3'd3 && s != 0) return 1 + (s + STEP - 1) / STEP;
      return 1;
   endfunction

   // Monitor: checks handshake outputs every cycle against the model.
   always @(negedge clk) begin
      if (reset) begin
         check_eq("rst_valid_o", bus.valid_o, 0);
         check_eq("rst_ready_o", bus.ready_o, 1);
         check_eq("rst_result", bus.result, 0);
         check_eq("rst_state", state_dbg, ST_IDLE);
         exp_q.delete();
         lat_q.delete();
         acc_q.delete();
      end else begin
         mon_ev = (exp_q.size() > 0) && (cyc - acc_q[0] + 1 >= lat_q[0]);
         check_eq("valid_o", bus.valid_o, mon_ev);
         if (mon_ev) begin
            check_eq("result", bus.result, exp_q[0]);
            check_eq("ready_o_done", bus.ready_o, bus.ready_i);
         end else if (exp_q.size() > 0) begin
            check_eq("ready_o_busy", bus.ready_o, 0);
         end else begin
            check_eq("ready_o_idle", bus.ready_o, 1);
         end
         if (mon_ev && bus.ready_i) begin
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
            void'(acc_q.pop_front());
         end
         if (bus.valid_i && bus.ready_o) begin
            exp_q.push_back(ref_op(bus.funct, bus.a, bus.b, int'(bus.shamt)));
            lat_q.push_back(ref_lat(bus.funct, int'(bus.shamt)));
            acc_q.push_back(cyc + 1);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic issue(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [SW-1:0] s, input bit rnd_ready);
      bus.valid_i = 1'b1;
      bus.funct   = f;
      bus.a       = a;
      bus.b       = b;
      bus.shamt   = s;
      for (int i = 0; ; i++) begin
         @(negedge clk);
         if (bus.ready_o) break;
         if (i >= 200) begin
            check_eq("issue_timeout", bus.ready_o, 1);
            bus.valid_i = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
         if (rnd_ready) bus.ready_i = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
      bus.valid_i = 1'b0;
      bus.a       = $urandom;
      bus.b       = $urandom;
      bus.shamt   = SW'($urandom);
      bus.funct   = 3'($urandom);
      if (rnd_ready) bus.ready_i = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_result(input string tag, input logic [W-1:0] exp);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.valid_o) begin
            check_eq(tag, bus.result, exp);
            return;
         end
      end
      check_eq({tag, "_timeout"}, bus.valid_o, 1);
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b1;
      bus.funct   = '0;
      bus.a       = '0;
      bus.b       = '0;
      bus.shamt   = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      issue(3'd0, 32'h0000_0001, '0, 5'd31, 0);
      wait_result("shl_31", 32'h8000_0000);
      idle_cycle();

      issue(3'd2, 32'h8000_0000, '0, 5'd4, 0);
      issue(3'd1, 32'h8000_0000, '0, 5'd4, 0);
      wait_result("shr_4", 32'h0800_0000);
      idle_cycle();

      issue(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd8, 0);
      wait_result("fshr_8", 32'h789A_BCDE);
      idle_cycle();
      issue(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0, 0);
      wait_result("fshr_0", 32'h9ABC_DEF0);
      idle_cycle();
      issue(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd31, 0);
      wait_result("fshr_31", 32'h2468_ACF1);
      idle_cycle();

      bus.ready_i = 1'b0;
      issue(3'd1, 32'hF0F0_0000, '0, 5'd4, 0);
      repeat (5) idle_cycle();
      bus.ready_i = 1'b1;
      issue(3'd0, 32'h0000_0003, '0, 5'd2, 0);
      wait_result("bp_next", 32'h0000_000C);
      idle_cycle();

      issue(3'd5, 32'h0000_00FF, '0, 5'd4, 0);
`ifdef ALU_SHIFT_ROTATE_EN
      wait_result("ror_4", 32'hF000_000F);
`else
      wait_result("ror_4", 32'h0000_00FF);
`endif
      idle_cycle();
      issue(3'd7, 32'hDEAD_BEEF, '0, 5'd9, 0);
      wait_result("illegal", 32'hDEAD_BEEF);
      idle_cycle();

      issue(3'd3, $urandom, $urandom, 5'd20, 0);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      issue(3'd0, 32'h0000_0005, '0, 5'd1, 0);
      wait_result("after_reset", 32'h0000_000A);
      idle_cycle();

      for (int n = 0; n < 300; n++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            idle_cycle();
            bus.ready_i = 1'($urandom_range(0, 1));
         end
         issue(3'($urandom_range(0, 7)), $urandom, $urandom,
               SW'($urandom_range(0, W - 1)), 1);
      end

      bus.ready_i = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      check_eq("drain", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_shift_pipe.md
# alu_shift_pipe

Parametrised shift/rotate/funnel unit for the ALU datapath, successor to the fixed 32-bit shifter. Accepts one operation per handshake on a valid/ready input, computes simple shifts in one cycle and funnel shifts iteratively at STEP bits per cycle. Holds the result in an output register until the consumer accepts it. Sits beside the other ALU execution units behind the ALU dispatch stage.

## Interface
- WIDTH, 32, operand/result width; power of two, ≥ 8
- STEP, 4, funnel bits shifted per BUSY cycle; power of two, 1..WIDTH
- SHAMT_W, $clog2(WIDTH), derived; shift-amount width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- valid_i  in  1  request valid
- ready_o  out  1  unit can accept a request this cycle
- funct  in  3  operation code
- a  in  WIDTH  operand / funnel high word
- b  in  WIDTH  funnel low word; ignored by non-funnel ops
- shamt  in  SHAMT_W  shift amount
- valid_o  out  1  result valid
- ready_i  in  1  consumer accepts result
- result  out  WIDTH  registered result

## Operation
- funct: 000 SHL a<<shamt; 001 SHR a>>shamt logical; 010 ASHR signed a>>>shamt; 011 FSHR low WIDTH bits of {a,b}>>shamt; 100 ROL; 101 ROR; 110/111 illegal: result = a.
- Accept = valid_i && ready_o; a, b, shamt, funct sampled only on accept.
- FSM states: IDLE, BUSY, DONE.
- IDLE: ready_o=1. Accept non-funnel → register result, go DONE. Accept FSHR → load {a,b} into 2·WIDTH work register and remaining=shamt; remaining==0 → result=b, go DONE; else go BUSY.
- BUSY: ready_o=0. Each cycle shift work register right by min(STEP, remaining), remaining -= that amount; when new remaining==0, result=work[WIDTH-1:0] of shifted value, go DONE.
- DONE: valid_o=1; result stable until accepted. ready_o = ready_i. On ready_i: new accept handled exactly as in IDLE (back-to-back); no accept → IDLE.
- valid_i while BUSY ignored; requester must hold until ready_o.
- shamt = 0 on any op → result = a (FSHR: b).

## Timing
- Reset (async, any state incl. mid-BUSY): state=IDLE, valid_o=0, ready_o=1, result=0, work register and remaining=0; in-flight op discarded.
- Non-funnel: accept at edge N → valid_o high after edge N+1 (1-cycle latency); throughput 1/cycle with ready_i held high.
- FSHR: valid_o after edge N+1+ceil(shamt/STEP); worst case ceil((WIDTH-1)/STEP) BUSY cycles.
- ready_o in DONE is combinational from ready_i; no other combinational input→output paths.
- valid_o never drops without ready_i; result never changes while valid_o && !ready_i.

## Configuration
- ALU_SHIFT_ROTATE_EN defined: ROL/ROR implemented as above.
- Not defined: rotate logic removed; funct 100/101 treated as illegal (result = a, 1-cycle latency).

## Structure
- Package alu_shift_pkg: funct localparams (SHL…ROR), FSM state encoding, default WIDTH/STEP.
- Sub-module alu_shift_core: combinational single-cycle SHL/SHR/ASHR/ROL/ROR for WIDTH, instantiated once; FSM, funnel iterator and handshake in top.

## Test plan (WIDTH=32, STEP=4)
- SHL a=0x0000_0001 shamt=31, ready_i=1 → valid_o next cycle, result 0x8000_0000.
- ASHR a=0x8000_0000 shamt=4 then SHR same → 0xF800_0000 then 0x0800_0000 on consecutive cycles, back-to-back accepts.
- FSHR a=0x1234_5678 b=0x9ABC_DEF0 shamt=8 → 2 BUSY cycles, ready_o=0 meanwhile, result 0x789A_BCDE at accept+3; shamt=0 → 0x9ABC_DEF0 at accept+1; shamt=31 → 8 BUSY cycles.
- Backpressure: SHR result with ready_i=0 for 5 cycles → valid_o, result stable, ready_o=0; ready_i=1 with new valid_i → accept same cycle.
- ROR a=0x0000_00FF shamt=4 → 0xF000_000F with ALU_SHIFT_ROTATE_EN; 0x0000_00FF without.
- Reset asserted mid-BUSY (FSHR shamt=20) → immediately valid_o=0, result=0, ready_o=1; next request completes normally.
